bit_serializer: RTL and testbench

- Upstream stage of the Mealy "two consecutive 1s" detector.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clk.
- Drives the detector's serial input `in` from `sout`.
- Back-to-back words are emitted with no gap, so bit patterns spanning a word boundary reach the detector intact.

---
 rtl/bit_serializer_if.sv | 22 ++
 rtl/bit_serializer.sv | 142 ++++++++++++++
 tb/tb_bit_serializer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/bit_serializer_if.sv
// Parallel-in / serial-out handshake bundle between a word source and bit_serializer.
// master drives words in and observes the serial stream; slave is the serializer.
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             last;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, last
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, last
  );
endinterface

// File: rtl/bit_serializer.sv
// Word-to-bit serializer feeding the two-consecutive-1s detector; gapless back-to-back frames.
// Optional even-parity trailer bit when SERIALIZER_PARITY_EN is defined.
module bit_serializer #(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input logic             clk,
  input logic             areset,
  bit_serializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT
`ifdef SERIALIZER_PARITY_EN
    , ST_PAR
`endif
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_sout;
  logic             r_sout_valid;
  logic             r_last;

  state_t           w_state_next;
  logic [CW-1:0]    w_cnt_next;
  logic [WIDTH-1:0] w_shift_next;
  logic             w_sout_next;
  logic             w_valid_next;
  logic             w_last_next;
  logic             w_load;
  logic             w_ready;
  logic             w_xfer;
  logic             w_load_bit;
  logic [WIDTH-1:0] w_load_rest;
  logic             w_shift_bit;
  logic [WIDTH-1:0] w_shift_rest;

`ifdef SERIALIZER_PARITY_EN
  logic r_par;
  logic w_par_next;
  assign w_ready = areset && ((r_state == ST_IDLE) || (r_state == ST_PAR));
`else
  // Ready during the final data bit lets the next word follow with no gap.
  assign w_ready = areset && ((r_state == ST_IDLE) ||
                              ((r_state == ST_SHIFT) && (r_cnt == '0)));
`endif

  assign w_xfer       = bus.din_valid && w_ready;
  assign w_load_bit   = MSB_FIRST ? bus.din[WIDTH-1] : bus.din[0];
  assign w_load_rest  = MSB_FIRST ? (bus.din << 1) : (bus.din >> 1);
  assign w_shift_bit  = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
  assign w_shift_rest = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_shift_next = r_shift;
    w_sout_next  = IDLE_LEVEL;
    w_valid_next = 1'b0;
    w_last_next  = 1'b0;
    w_load       = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    w_par_next   = r_par;
`endif
    case (r_state)
      ST_IDLE: w_load = w_xfer;
      ST_SHIFT: begin
        if (r_cnt != '0) begin
          w_cnt_next   = r_cnt - CW'(1);
          w_shift_next = w_shift_rest;
          w_sout_next  = w_shift_bit;
          w_valid_next = 1'b1;
`ifndef SERIALIZER_PARITY_EN
          w_last_next  = (r_cnt == CW'(1));
`endif
        end else begin
`ifdef SERIALIZER_PARITY_EN
          w_state_next = ST_PAR;
          w_sout_next  = r_par;
          w_valid_next = 1'b1;
          w_last_next  = 1'b1;
`else
          w_load = w_xfer;
          if (!w_xfer) w_state_next = ST_IDLE;
`endif
        end
      end
`ifdef SERIALIZER_PARITY_EN
      ST_PAR: begin
        w_load = w_xfer;
        if (!w_xfer) w_state_next = ST_IDLE;
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
    if (w_load) begin
      w_state_next = ST_SHIFT;
      w_cnt_next   = CW'(WIDTH - 1);
      w_shift_next = w_load_rest;
      w_sout_next  = w_load_bit;
      w_valid_next = 1'b1;
      w_last_next  = 1'b0;
`ifdef SERIALIZER_PARITY_EN
      w_par_next   = ^bus.din;
`endif
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_sout       <= IDLE_LEVEL;
      r_sout_valid <= 1'b0;
      r_last       <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      r_par        <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_shift      <= w_shift_next;
      r_sout       <= w_sout_next;
      r_sout_valid <= w_valid_next;
      r_last       <= w_last_next;
`ifdef SERIALIZER_PARITY_EN
      r_par        <= w_par_next;
`endif
    end
  end

  assign bus.din_ready  = w_ready;
  assign bus.sout       = r_sout;
  assign bus.sout_valid = r_sout_valid;
  assign bus.last       = r_last;
endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: MSB-first and LSB-first instances, table vectors plus
// reset-abort, input-stability and back-to-back sequences (parity-aware via SERIALIZER_PARITY_EN).
module tb_bit_serializer;
`ifdef SERIALIZER_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif
  localparam logic [8:0] VMASK = (FL == 9) ? 9'h1FF : 9'h0FF;

  logic clk = 1'b0;
  logic areset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(8)) bus_m ();
  bit_serializer_if #(.WIDTH(8)) bus_l ();

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
    .clk(clk), .areset(areset), .bus(bus_m));
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
    .clk(clk), .areset(areset), .bus(bus_l));

  typedef struct {
    bit         lsb;
    logic [7:0] din;
    logic [7:0] exp_bits;  // emission order, first bit at [7]
    logic       exp_par;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input bit lsb, input logic [7:0] d, input logic v);
    if (lsb) begin bus_l.din = d; bus_l.din_valid = v; end
    else     begin bus_m.din = d; bus_m.din_valid = v; end
  endtask

  task automatic sample(input bit lsb, output logic s, output logic v,
                        output logic l, output logic r);
    if (lsb) begin s = bus_l.sout; v = bus_l.sout_valid; l = bus_l.last; r = bus_l.din_ready; end
    else     begin s = bus_m.sout; v = bus_m.sout_valid; l = bus_m.last; r = bus_m.din_ready; end
  endtask

  function automatic logic [8:0] frame_of(input logic [7:0] bits, input logic par);
`ifdef SERIALIZER_PARITY_EN
    return {bits, par};
`else
    return {1'b0, bits};
`endif
  endfunction

  // One word through one instance; called while clk is low with the DUT idle.
  // When stress is set, din is scrambled and din_valid held while ready is low.
  task automatic run_frame(input bit lsb, input logic [7:0] d, input logic [8:0] exp_seq,
                           input string name, input bit stress);
    logic [8:0] seq, vm, lm, rm;
    logic s, v, l, r;
    seq = '0; vm = '0; lm = '0; rm = '0;
    set_in(lsb, d, 1'b1);
    @(negedge clk);
    set_in(lsb, d, 1'b0);
    for (int k = 0; k < FL; k++) begin
      if (stress) set_in(lsb, 8'($urandom), (k < FL - 1));
      sample(lsb, s, v, l, r);
      seq = {seq[7:0], s}; vm = {vm[7:0], v}; lm = {lm[7:0], l}; rm = {rm[7:0], r};
      @(negedge clk);
    end
    set_in(lsb, 8'h00, 1'b0);
    chk({name, " bits"},  32'(seq), 32'(exp_seq));
    chk({name, " valid"}, 32'(vm), 32'(VMASK));
    chk({name, " last"},  32'(lm), 32'h1);
    chk({name, " ready"}, 32'(rm), 32'h1);
    sample(lsb, s, v, l, r);
    chk({name, " idle sout"},  32'(s), 32'h0);
    chk({name, " idle valid"}, 32'(v), 32'h0);
    chk({name, " idle ready"}, 32'(r), 32'h1);
    $display("[TB] frame %s din=%02h bits=%03h", name, d, seq);
  endtask

  initial begin
    logic [17:0] stream;
    logic s, v, l, r, prev;
    int n, first, lastv, pulses, pulse_pos, acc;
    bit drop;

    vecs[0] = '{1'b0, 8'hA5, 8'b10100101, 1'b0};
    vecs[1] = '{1'b0, 8'h07, 8'b00000111, 1'b1};
    vecs[2] = '{1'b0, 8'h03, 8'b00000011, 1'b0};
    vecs[3] = '{1'b0, 8'h80, 8'b10000000, 1'b1};
    vecs[4] = '{1'b0, 8'hFF, 8'b11111111, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 8'b00000000, 1'b0};
    vecs[6] = '{1'b1, 8'h01, 8'b10000000, 1'b1};
    vecs[7] = '{1'b1, 8'h0E, 8'b01110000, 1'b1};
    vecs[8] = '{1'b1, 8'h80, 8'b00000001, 1'b1};

    areset = 1'b0;
    set_in(1'b0, 8'h00, 1'b0);
    set_in(1'b1, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    chk("reset sout",  32'(bus_m.sout), 32'h0);
    chk("reset valid", 32'(bus_m.sout_valid), 32'h0);
    chk("reset last",  32'(bus_m.last), 32'h0);
    chk("reset ready", 32'(bus_m.din_ready), 32'h0);
    chk("reset ready lsb", 32'(bus_l.din_ready), 32'h0);
    areset = 1'b1;
    #1;
    chk("release ready", 32'(bus_m.din_ready), 32'h1);

    foreach (vecs[i])
      run_frame(vecs[i].lsb, vecs[i].din, frame_of(vecs[i].exp_bits, vecs[i].exp_par),
                $sformatf("vec%0d", i), 1'b0);

    // Reset pulled mid-frame must abort immediately and never resume.
    set_in(1'b0, 8'hFF, 1'b1);
    @(negedge clk);
    set_in(1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    chk("abort pre valid", 32'(bus_m.sout_valid), 32'h1);
    areset = 1'b0;
    #1;
    chk("abort sout",  32'(bus_m.sout), 32'h0);
    chk("abort valid", 32'(bus_m.sout_valid), 32'h0);
    chk("abort ready", 32'(bus_m.din_ready), 32'h0);
    @(negedge clk);
    areset = 1'b1;
    #1;
    chk("abort release ready", 32'(bus_m.din_ready), 32'h1);
    @(negedge clk);
    chk("abort no resume", 32'(bus_m.sout_valid), 32'h0);
    run_frame(1'b0, 8'h01, frame_of(8'b00000001, 1'b1), "after_abort", 1'b0);

    run_frame(1'b0, 8'h3C, frame_of(8'b00111100, 1'b0), "stability", 1'b1);
    @(negedge clk);
    chk("stability no extra xfer", 32'(bus_m.sout_valid), 32'h0);

    // Back-to-back 0x81, 0x81 with din_valid held until the second acceptance.
    stream = '0; n = 0; first = -1; lastv = -1; acc = 1; drop = 1'b0;
    set_in(1'b0, 8'h81, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 2 * FL + 3; k++) begin
      if (drop) set_in(1'b0, 8'h00, 1'b0);
      sample(1'b0, s, v, l, r);
      if (bus_m.din_valid && r) begin
        acc++;
        if (acc == 2) drop = 1'b1;
      end
      if (v) begin
        stream = {stream[16:0], s};
        n++;
        if (first < 0) first = k;
        lastv = k;
      end
      @(negedge clk);
    end
    set_in(1'b0, 8'h00, 1'b0);
    pulses = 0; pulse_pos = 0; prev = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      if (stream[i] && prev) begin pulses++; pulse_pos = n - i; end
      prev = stream[i];
    end
    chk("b2b count", 32'(n), 32'(2 * FL));
    chk("b2b contiguous", 32'(lastv - first + 1), 32'(2 * FL));
    chk("b2b accepts", 32'(acc), 32'h2);
`ifdef SERIALIZER_PARITY_EN
    chk("b2b bits", 32'(stream), 32'(18'b100000010100000010));
    chk("b2b detector pulses", 32'(pulses), 32'h0);
`else
    chk("b2b bits", 32'(stream), 32'(18'h08181));
    chk("b2b detector pulses", 32'(pulses), 32'h1);
    chk("b2b detector pos", 32'(pulse_pos), 32'd9);
`endif
    $display("[TB] frame b2b 81/81 bits=%05h count=%0d", stream, n);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
